// File: rtl/duck_sprite_engine.sv
// Per-duck motion, animation and life-cycle engine for the Duck Hunt VGA path.
// Tracks one duck from spawn to shot-down or escape and maps pixels onto its sprite sheet.
module duck_sprite_engine #(
  parameter int SPR_W         = 64,
  parameter int SPR_H         = 64,
  parameter int SHEET_W       = 320,
  parameter int FRAMES        = 3,
  parameter int FRAME_DIV     = 11,
  parameter int X_STEP        = 1,
  parameter int Y_STEP        = 1,
  parameter int X_MIN         = 1,
  parameter int X_MAX         = 575,
  parameter int Y_MIN         = 16,
  parameter int Y_MAX         = 335,
  parameter int GROUND_Y      = 400,
  parameter int FALL_STEP     = 4,
  parameter int HIT_FRAMES    = 30,
  parameter int ESCAPE_FRAMES = 600,
  parameter int ADDR_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              start,
  input  logic [9:0]        start_x,
  input  logic [1:0]        start_dir,
  input  logic              shot,
  input  logic [9:0]        shot_x,
  input  logic [9:0]        shot_y,
  output logic              is_duck,
  output logic [ADDR_W-1:0] duck_addr,
  output logic              busy,
  output logic              hit,
  output logic              done,
  output logic              escaped
);
  localparam int ANIM_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HOLD_W   = $clog2(HIT_FRAMES + 1);
  localparam int FLIGHT_W = $clog2(ESCAPE_FRAMES + 1);

  localparam logic [9:0] XMIN     = 10'(X_MIN);
  localparam logic [9:0] XMAX     = 10'(X_MAX);
  localparam logic [9:0] YMIN     = 10'(Y_MIN);
  localparam logic [9:0] YMAX     = 10'(Y_MAX);
  localparam logic [9:0] XSTEP    = 10'(X_STEP);
  localparam logic [9:0] YSTEP    = 10'(Y_STEP);
  localparam logic [9:0] FSTEP    = 10'(FALL_STEP);
  localparam logic [9:0] GROUND   = 10'(GROUND_Y);

  typedef enum logic [2:0] {S_IDLE, S_FLY, S_HIT, S_FALL, S_ESCAPE, S_DONE} state_t;

  state_t              state;
  logic [9:0]          x, y;
  logic                right, down;
  logic [FRAME_W-1:0]  frame, frame_nxt;
  logic [ANIM_W-1:0]   anim_cnt, anim_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [FLIGHT_W-1:0] flight_cnt;
  logic                fc_meta, fc_cur, fc_prev, tick;
  logic [9:0]          start_clamped, shot_dx, shot_dy, y_fall, y_rise, pix_dx, pix_dy;
  logic                shot_in_box;
  logic [31:0]         row_base, col_base, addr;

  assign busy        = (state != S_IDLE);
  assign shot_dx     = shot_x - x;
  assign shot_dy     = shot_y - y;
  assign shot_in_box = ({22'd0, shot_dx} < 32'(SPR_W)) && ({22'd0, shot_dy} < 32'(SPR_H));
  assign y_fall      = y + FSTEP;
  assign y_rise      = y - YSTEP;

  always_comb begin
    start_clamped = start_x;
    if (start_x < XMIN)
      start_clamped = XMIN;
    else if (start_x > XMAX)
      start_clamped = XMAX;
  end

  always_comb begin
    anim_nxt  = anim_cnt + 1'b1;
    frame_nxt = frame;
    if (anim_cnt == ANIM_W'(FRAME_DIV - 1)) begin
      anim_nxt  = '0;
      frame_nxt = (frame == FRAME_W'(FRAMES - 1)) ? '0 : frame + 1'b1;
    end
  end

  // Bounce direction is decided from the position before this tick's step.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      x          <= XMIN;
      y          <= YMAX;
      right      <= 1'b0;
      down       <= 1'b0;
      frame      <= '0;
      anim_cnt   <= '0;
      hold_cnt   <= '0;
      flight_cnt <= '0;
      fc_meta    <= 1'b0;
      fc_cur     <= 1'b0;
      fc_prev    <= 1'b0;
      tick       <= 1'b0;
      hit        <= 1'b0;
      done       <= 1'b0;
      escaped    <= 1'b0;
    end else begin
      fc_meta <= frame_clk;
      fc_cur  <= fc_meta;
      fc_prev <= fc_cur;
      tick    <= fc_cur & ~fc_prev;
      hit     <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x          <= start_clamped;
            y          <= YMAX;
            right      <= start_dir[0];
            down       <= ~start_dir[1];
            frame      <= '0;
            anim_cnt   <= '0;
            hold_cnt   <= '0;
            flight_cnt <= '0;
            escaped    <= 1'b0;
            state      <= S_FLY;
          end
        end
        S_FLY: begin
          if (shot && shot_in_box) begin
            state    <= S_HIT;
            hit      <= 1'b1;
            hold_cnt <= '0;
          end else if (tick) begin
            x <= right ? x + XSTEP : x - XSTEP;
            y <= down ? y + YSTEP : y - YSTEP;
            if (x >= XMAX)
              right <= 1'b0;
            else if (x <= XMIN)
              right <= 1'b1;
            if (y >= YMAX)
              down <= 1'b0;
            else if (y <= YMIN)
              down <= 1'b1;
            anim_cnt   <= anim_nxt;
            frame      <= frame_nxt;
            flight_cnt <= flight_cnt + 1'b1;
            if (flight_cnt == FLIGHT_W'(ESCAPE_FRAMES - 1))
              state <= S_ESCAPE;
          end
        end
        S_HIT: begin
          if (tick) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_W'(HIT_FRAMES - 1))
              state <= S_FALL;
          end
        end
        S_FALL: begin
          if (tick) begin
            y        <= y_fall;
            anim_cnt <= anim_nxt;
            frame    <= frame_nxt;
            if (y_fall >= GROUND) begin
              state   <= S_DONE;
              done    <= 1'b1;
              escaped <= 1'b0;
            end
          end
        end
        S_ESCAPE: begin
          if (tick) begin
            y        <= y_rise;
            anim_cnt <= anim_nxt;
            frame    <= frame_nxt;
            if (y_rise < YSTEP) begin
              state   <= S_DONE;
              done    <= 1'b1;
              escaped <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sheet layout: flying rows by facing, one shared row for the hit/fall poses.
  always_comb begin
    row_base = 32'd0;
    col_base = 32'd0;
    case (state)
      S_HIT: begin
        row_base = 32'(2 * SPR_H);
        col_base = 32'd0;
      end
      S_FALL: begin
        row_base = 32'(2 * SPR_H);
        col_base = frame[0] ? 32'(2 * SPR_W) : 32'(SPR_W);
      end
      default: begin
        row_base = right ? 32'd0 : 32'(SPR_H);
        col_base = 32'(frame) * 32'(SPR_W);
      end
    endcase
  end

  assign pix_dx    = DrawX - x;
  assign pix_dy    = DrawY - y;
  assign is_duck   = busy && ({22'd0, pix_dx} < 32'(SPR_W)) && ({22'd0, pix_dy} < 32'(SPR_H));
  assign addr      = (row_base + {22'd0, pix_dy}) * 32'(SHEET_W) + col_base + {22'd0, pix_dx};
  assign duck_addr = (is_duck && ((addr >> ADDR_W) == 32'd0)) ? addr[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_duck_sprite_engine.sv
// Scoreboard bench for duck_sprite_engine: a behavioural duck model predicts pixels
// and queues the hit/done events the engine must raise.
module tb_duck_sprite_engine;
  localparam int SPR_W         = 64;
  localparam int SPR_H         = 64;
  localparam int SHEET_W       = 320;
  localparam int FRAMES        = 3;
  localparam int FRAME_DIV     = 11;
  localparam int X_MIN         = 1;
  localparam int X_MAX         = 575;
  localparam int Y_MIN         = 16;
  localparam int Y_MAX         = 335;
  localparam int GROUND_Y      = 400;
  localparam int FALL_STEP     = 4;
  localparam int HIT_FRAMES    = 30;
  localparam int ESCAPE_FRAMES = 600;

  typedef enum int {M_IDLE, M_FLY, M_HIT, M_FALL, M_ESC} mstate_t;
  typedef struct {
    logic [1:0] ev;
    logic       esc;
  } ev_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        start = 1'b0;
  logic [9:0]  start_x = '0;
  logic [1:0]  start_dir = '0;
  logic        shot = 1'b0;
  logic [9:0]  shot_x = '0, shot_y = '0;
  logic        is_duck, busy, hit, done, escaped;
  logic [15:0] duck_addr;

  ev_t     exp_q[$];
  ev_t     cur_ev;
  int      n_checks = 0;
  int      n_fail = 0;
  int      mx, my, mframe, manim, mflight, mhold;
  bit      mright, mdown, mesc;
  mstate_t mst;
  int      ox, oy;

  duck_sprite_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .start(start), .start_x(start_x), .start_dir(start_dir), .shot(shot),
    .shot_x(shot_x), .shot_y(shot_y), .is_duck(is_duck), .duck_addr(duck_addr),
    .busy(busy), .hit(hit), .done(done), .escaped(escaped)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every hit/done pulse must match the oldest event the model queued.
  always @(negedge Clk) begin
    if (!Reset && (hit || done)) begin
      cur_ev.ev  = 2'b00;
      cur_ev.esc = 1'b0;
      if (exp_q.size() > 0)
        cur_ev = exp_q.pop_front();
      checkOutput("event", {30'd0, done, hit}, {30'd0, cur_ev.ev});
      if (done)
        checkOutput("done_escaped", {31'd0, escaped}, {31'd0, cur_ev.esc});
    end
  end

  task automatic modelReset();
    mx = X_MIN; my = Y_MAX; mframe = 0; manim = 0; mflight = 0; mhold = 0;
    mright = 1'b0; mdown = 1'b0; mesc = 1'b0; mst = M_IDLE;
  endtask

  task automatic modelAnim();
    manim++;
    if (manim == FRAME_DIV) begin
      manim  = 0;
      mframe = (mframe + 1) % FRAMES;
    end
  endtask

  task automatic modelTick();
    int px, py;
    px = mx;
    py = my;
    case (mst)
      M_FLY: begin
        mx = mright ? px + 1 : px - 1;
        my = mdown ? py + 1 : py - 1;
        if (px >= X_MAX) mright = 1'b0;
        else if (px <= X_MIN) mright = 1'b1;
        if (py >= Y_MAX) mdown = 1'b0;
        else if (py <= Y_MIN) mdown = 1'b1;
        modelAnim();
        mflight++;
        if (mflight == ESCAPE_FRAMES) mst = M_ESC;
      end
      M_HIT: begin
        mhold++;
        if (mhold == HIT_FRAMES) mst = M_FALL;
      end
      M_FALL: begin
        my = py + FALL_STEP;
        modelAnim();
        if (my >= GROUND_Y) begin
          exp_q.push_back('{2'b10, 1'b0});
          mesc = 1'b0;
          mst  = M_IDLE;
        end
      end
      M_ESC: begin
        my = py - 1;
        modelAnim();
        if (my < 1) begin
          exp_q.push_back('{2'b10, 1'b1});
          mesc = 1'b1;
          mst  = M_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  function automatic bit modelShotHits(input int sx, input int sy);
    return (mst == M_FLY) && (((sx - mx) & 1023) < SPR_W) && (((sy - my) & 1023) < SPR_H);
  endfunction

  // One frame strobe (optionally with a shot landing on the tick cycle), or a lone shot.
  task automatic applyStimulus(input bit tk, input bit sh, input int sx, input int sy);
    if (tk) begin
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
    end
    shot   = sh;
    shot_x = 10'(sx);
    shot_y = 10'(sy);
    if (sh && modelShotHits(sx, sy)) begin
      exp_q.push_back('{2'b01, 1'b0});
      mst   = M_HIT;
      mhold = 0;
    end else if (tk) begin
      modelTick();
    end
    @(negedge Clk);
    shot      = 1'b0;
    frame_clk = 1'b0;
    if (tk) repeat (4) @(negedge Clk);
  endtask

  task automatic checkPixel(input int px, input int py);
    int dx, dy, row, col, ex_addr;
    bit isd;
    DrawX = 10'(px);
    DrawY = 10'(py);
    #1;
    dx  = (px - mx) & 1023;
    dy  = (py - my) & 1023;
    isd = (mst != M_IDLE) && (dx < SPR_W) && (dy < SPR_H);
    if (mst == M_HIT || mst == M_FALL) row = 2 * SPR_H;
    else row = mright ? 0 : SPR_H;
    if (mst == M_HIT) col = 0;
    else if (mst == M_FALL) col = ((mframe % 2) != 0) ? 2 * SPR_W : SPR_W;
    else col = mframe * SPR_W;
    ex_addr = isd ? (row + dy) * SHEET_W + col + dx : 0;
    checkOutput("is_duck", 32'(is_duck), 32'(isd));
    checkOutput("duck_addr", 32'(duck_addr), ex_addr);
  endtask

  task automatic doStart(input int sx, input logic [1:0] dir);
    start     = 1'b1;
    start_x   = 10'(sx);
    start_dir = dir;
    @(negedge Clk);
    start   = 1'b0;
    mx      = (sx < X_MIN) ? X_MIN : ((sx > X_MAX) ? X_MAX : sx);
    my      = Y_MAX;
    mright  = dir[0];
    mdown   = !dir[1];
    mframe  = 0; manim = 0; mflight = 0; mhold = 0;
    mesc    = 1'b0;
    mst     = M_FLY;
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("escaped_after_start", 32'(escaped), 32'(mesc));
  endtask

  task automatic doReset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    modelReset();
    @(negedge Clk);
  endtask

  initial begin
    modelReset();
    doReset();
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_hit", 32'(hit), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_escaped", 32'(escaped), 0);
    checkPixel(X_MIN, Y_MAX);

    // Spawn right/up, then misses on the box edges, a hit, and the full fall.
    doStart(320, 2'b11);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkPixel(321, 334);
    checkPixel(321 + 63, 334 + 63);
    checkPixel(321 + 64, 334);
    checkPixel(320, 334);
    applyStimulus(1'b0, 1'b1, mx + 64, my);
    checkOutput("miss_busy", 32'(busy), 1);
    applyStimulus(1'b0, 1'b1, mx, my + 64);
    applyStimulus(1'b0, 1'b1, mx - 1, my);
    checkPixel(mx, my);
    applyStimulus(1'b0, 1'b1, mx + 63, my + 63);
    checkPixel(mx, my);
    checkPixel(mx + 10, my + 5);
    for (int i = 0; i < 200 && mst != M_IDLE; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 0);
      if (mst != M_IDLE) checkPixel(mx + (i % 64), my + 3);
    end
    checkOutput("fall_busy_end", 32'(busy), 0);
    checkOutput("fall_escaped", 32'(escaped), 0);
    checkOutput("fall_pending", exp_q.size(), 0);
    checkPixel(mx, my);

    // Shot on the tick cycle freezes motion; reset during the fall aborts silently.
    doStart(200, 2'b10);
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, mx + 10, my + 10);
    checkPixel(mx, my);
    checkPixel(mx - 1, my);
    for (int i = 0; i < 40 && mst != M_FALL; i++) applyStimulus(1'b1, 1'b0, 0, 0);
    repeat (2) applyStimulus(1'b1, 1'b0, 0, 0);
    checkPixel(mx, my);
    ox = mx;
    oy = my;
    Reset = 1'b1;
    @(negedge Clk);
    modelReset();
    checkOutput("midfall_reset_busy", 32'(busy), 0);
    checkOutput("midfall_reset_done", 32'(done), 0);
    checkPixel(ox, oy);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("midfall_pending", exp_q.size(), 0);

    // Right-wall bounce, then a long unshot flight into escape with ignored shots.
    doStart(574, 2'b01);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkPixel(mx, my);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkPixel(mx, my);
    applyStimulus(1'b1, 1'b0, 0, 0);
    checkPixel(575, my);
    for (int i = 0; i < 700 && mst == M_FLY; i++) begin
      applyStimulus(1'b1, 1'b0, 0, 0);
      if (i % 97 == 0) checkPixel(mx + 5, my + 7);
    end
    checkOutput("escape_busy", 32'(busy), 1);
    for (int i = 0; i < 400 && mst != M_IDLE; i++) begin
      applyStimulus(1'b1, (i % 2) == 1, mx + 5, my + 5);
      if (i % 3 == 0) applyStimulus(1'b0, 1'b1, mx, my);
      if (mst != M_IDLE && i % 40 == 0) checkPixel(mx + 2, my + 1);
    end
    checkOutput("escape_busy_end", 32'(busy), 0);
    checkOutput("escape_escaped", 32'(escaped), 32'(mesc));
    checkOutput("escape_pending", exp_q.size(), 0);
    repeat (5) @(negedge Clk);
    checkOutput("escaped_holds", 32'(escaped), 32'(mesc));

    // Out-of-range spawn clamps to the right limit.
    doStart(700, 2'b01);
    checkPixel(575, 335);
    checkPixel(574, 335);
    repeat (3) @(negedge Clk);
    checkOutput("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
